vcve2_counter_bank: RTL and testbench
=====================================

VCVE2_COUNTER_BANK -- requirements
Module: vcve2_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 4, meaning number of independent counters (range 1..29).
REQ-002 SHALL have parameter CounterWidth, default 40, meaning implemented bits per counter (range 1..64).
REQ-003 SHALL have parameter NumEvents, default 16, meaning number of event inputs (range 1..255).
REQ-004 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port events_i  in  NumEvents  per-cycle event strobes.
REQ-007 SHALL have port inhibit_i  in  NumCounters  per-counter count inhibit.
REQ-008 SHALL have port idx_i  in  5  counter index for write and read.
REQ-009 SHALL have port we_lo_i / we_hi_i / we_sel_i  in  1 each  write low half, high half, event select.
REQ-010 SHALL have port wdata_i  in  32  write data.
REQ-011 SHALL have port ovf_clr_i  in  NumCounters  overflow flag clear.
REQ-012 SHALL have port rdata_o  out  64  value of counter idx_i, zero-extended.
REQ-013 SHALL have port sel_o  out  8  event select of counter idx_i.
REQ-014 SHALL have port ovf_o  out  NumCounters  sticky overflow flags.
REQ-015 SHALL have port irq_o  out  1  OR of ovf_o.

Function
REQ-016 Event select SHALL be 8 bits per counter: 0 = never count; k in 1..NumEvents = count when events_i[k-1]; k > NumEvents = never count.
REQ-017 Counter n SHALL increment by 1 on a cycle where its selected event is 1, inhibit_i[n] = 0, and no write targets n.
REQ-018 Increment from all-ones (CounterWidth bits) SHALL wrap to 0 and set ovf_o[n] on the same edge.
REQ-019 Writes SHALL act only when idx_i < NumCounters; otherwise ignored with no side effect.
REQ-020 we_lo_i SHALL load bits 31:0 from wdata_i; we_hi_i SHALL load bits 63:32; bits at or above CounterWidth SHALL be discarded.
REQ-021 we_lo_i and we_hi_i together SHALL load wdata_i into both halves.
REQ-022 A counter write SHALL take priority over a same-cycle increment of that counter; the increment is lost and no overflow is set.
REQ-023 we_sel_i SHALL load wdata_i[7:0] into the select of counter idx_i; a same-cycle increment SHALL use the old select.
REQ-024 ovf_clr_i[n] SHALL clear ovf_o[n]; a same-cycle overflow set SHALL win over clear.
REQ-025 rdata_o and sel_o SHALL be combinational from current state (zero latency); idx_i >= NumCounters SHALL read 0.
REQ-026 rdata_o bits at or above CounterWidth SHALL read 0.
REQ-027 irq_o SHALL be registered-state combinational OR of ovf_o, no extra latency.

Reset
REQ-028 On rst_ni low all counters, selects and ovf_o SHALL be 0 asynchronously; rdata_o, sel_o, irq_o follow as 0.
REQ-029 Reset mid-count SHALL discard pending increments and writes; counting resumes on the first edge after release.

Structure
REQ-030 A shared package SHALL hold EvSelW = 8, IdxW = 5 and MaxCounters = 29.
REQ-031 One sub-module vcve2_counter_bank_cnt SHALL implement a single counter with its select and overflow flag, instantiated NumCounters times in a generate loop.
REQ-032 No multi-cycle paths; the single-cycle increment SHALL be a plain adder per counter.

Verification
REQ-033 Reset, sel[0]=1, events_i[0] high 5 cycles -> rdata_o(idx 0) = 5, other counters 0.
REQ-034 CounterWidth=8, counter 1 loaded 0xFF, one event -> rdata_o = 0, ovf_o[1]=1, irq_o=1; ovf_clr_i[1] -> 0.
REQ-035 Counter 2 counting every cycle, we_lo_i with wdata 0x100 -> next value 0x100 (not 0x101), then 0x101.
REQ-036 inhibit_i[3]=1 with event active 10 cycles -> counter 3 unchanged; release -> counts.
REQ-037 idx_i=30 with we_lo_i/we_sel_i -> no state change, rdata_o=0, sel_o=0.
REQ-038 Overflow and ovf_clr_i same cycle -> ovf_o stays 1; rst_ni pulse mid-count -> all outputs 0.

Source files
------------

// File: rtl/vcve2_counter_bank_pkg.sv
// Shared widths and limits for the event counter bank.
package vcve2_counter_bank_pkg;

  localparam int unsigned EvSelW      = 8;
  localparam int unsigned IdxW        = 5;
  localparam int unsigned MaxCounters = 29;
  localparam int unsigned RdataW      = 64;
  localparam int unsigned WdataW      = 32;

endpackage

// File: rtl/vcve2_counter_bank_cnt.sv
// One event counter: event select, inhibit, split 32-bit writes and a sticky overflow flag.
module vcve2_counter_bank_cnt
  import vcve2_counter_bank_pkg::*;
#(
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 inhibit_i,
  input  logic                 we_lo_i,
  input  logic                 we_hi_i,
  input  logic                 we_sel_i,
  input  logic [WdataW-1:0]    wdata_i,
  input  logic                 ovf_clr_i,
  output logic [RdataW-1:0]    cnt_o,
  output logic [EvSelW-1:0]    sel_o,
  output logic                 ovf_o
);

  logic [CounterWidth-1:0] cnt_q, cnt_d, wr_val;
  logic [CounterWidth:0]   inc_sum;
  logic [EvSelW-1:0]       sel_q, sel_d;
  logic                    ovf_q, ovf_d;
  logic                    ev_hit, wr_cnt, inc_en;

  // Select 0 and selects beyond NumEvents match no event.
  always_comb begin
    ev_hit = 1'b0;
    for (int unsigned i = 0; i < NumEvents; i++) begin
      if (sel_q == EvSelW'(i + 1)) ev_hit = events_i[i];
    end
  end

  // Bits below 32 come from a low write, the rest from a high write.
  always_comb begin
    wr_val = cnt_q;
    for (int unsigned b = 0; b < CounterWidth; b++) begin
      if ((b < WdataW) ? we_lo_i : we_hi_i) wr_val[b] = wdata_i[b % WdataW];
    end
  end

  always_comb begin
    wr_cnt  = we_lo_i | we_hi_i;
    inc_en  = ev_hit & ~inhibit_i & ~wr_cnt;
    inc_sum = {1'b0, cnt_q} + (CounterWidth + 1)'(1);
    if (wr_cnt) begin
      cnt_d = wr_val;
    end else if (inc_en) begin
      cnt_d = inc_sum[CounterWidth-1:0];
    end else begin
      cnt_d = cnt_q;
    end
    ovf_d = (inc_en & inc_sum[CounterWidth]) | (ovf_q & ~ovf_clr_i);
    sel_d = we_sel_i ? wdata_i[EvSelW-1:0] : sel_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    cnt_o = RdataW'(cnt_q);
    sel_o = sel_q;
    ovf_o = ovf_q;
  end

endmodule

// File: rtl/vcve2_counter_bank.sv
// Bank of independent event counters with indexed write/read access and overflow interrupt.
module vcve2_counter_bank
  import vcve2_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   events_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic                   we_lo_i,
  input  logic                   we_hi_i,
  input  logic                   we_sel_i,
  input  logic [WdataW-1:0]      wdata_i,
  input  logic [NumCounters-1:0] ovf_clr_i,
  output logic [RdataW-1:0]      rdata_o,
  output logic [EvSelW-1:0]      sel_o,
  output logic [NumCounters-1:0] ovf_o,
  output logic                   irq_o
);

  if (NumCounters < 1 || NumCounters > MaxCounters) begin : g_bad_num_counters
    $error("NumCounters out of range");
  end

  logic [RdataW-1:0] cnt_val [NumCounters];
  logic [EvSelW-1:0] sel_val [NumCounters];

  // An out-of-range index matches no counter, so writes to it vanish.
  for (genvar n = 0; n < NumCounters; n++) begin : g_cnt
    logic idx_hit;
    assign idx_hit = (idx_i == IdxW'(n));

    vcve2_counter_bank_cnt #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .events_i  (events_i),
      .inhibit_i (inhibit_i[n]),
      .we_lo_i   (we_lo_i & idx_hit),
      .we_hi_i   (we_hi_i & idx_hit),
      .we_sel_i  (we_sel_i & idx_hit),
      .wdata_i   (wdata_i),
      .ovf_clr_i (ovf_clr_i[n]),
      .cnt_o     (cnt_val[n]),
      .sel_o     (sel_val[n]),
      .ovf_o     (ovf_o[n])
    );
  end

  always_comb begin
    rdata_o = '0;
    sel_o   = '0;
    for (int unsigned n = 0; n < NumCounters; n++) begin
      if (idx_i == IdxW'(n)) begin
        rdata_o = cnt_val[n];
        sel_o   = sel_val[n];
      end
    end
  end

  assign irq_o = |ovf_o;

endmodule

// File: tb/tb_vcve2_counter_bank.sv
// Directed bench: a 40-bit bank (a_*) and an 8-bit bank (b_*) share one stimulus stream.
module tb_vcve2_counter_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] events_i;
  logic [3:0]  inhibit_i;
  logic [4:0]  idx_i;
  logic        we_lo_i, we_hi_i, we_sel_i;
  logic [31:0] wdata_i;
  logic [3:0]  ovf_clr_i;

  logic [63:0] a_rdata, b_rdata;
  logic [7:0]  a_sel, b_sel;
  logic [3:0]  a_ovf, b_ovf;
  logic        a_irq, b_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  vcve2_counter_bank #(
    .NumCounters  (4),
    .CounterWidth (40),
    .NumEvents    (16)
  ) u_dut_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .events_i  (events_i),
    .inhibit_i (inhibit_i),
    .idx_i     (idx_i),
    .we_lo_i   (we_lo_i),
    .we_hi_i   (we_hi_i),
    .we_sel_i  (we_sel_i),
    .wdata_i   (wdata_i),
    .ovf_clr_i (ovf_clr_i),
    .rdata_o   (a_rdata),
    .sel_o     (a_sel),
    .ovf_o     (a_ovf),
    .irq_o     (a_irq)
  );

  vcve2_counter_bank #(
    .NumCounters  (4),
    .CounterWidth (8),
    .NumEvents    (16)
  ) u_dut_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .events_i  (events_i),
    .inhibit_i (inhibit_i),
    .idx_i     (idx_i),
    .we_lo_i   (we_lo_i),
    .we_hi_i   (we_hi_i),
    .we_sel_i  (we_sel_i),
    .wdata_i   (wdata_i),
    .ovf_clr_i (ovf_clr_i),
    .rdata_o   (b_rdata),
    .sel_o     (b_sel),
    .ovf_o     (b_ovf),
    .irq_o     (b_irq)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx);
    idx_i = idx;
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic lo, input logic hi,
                    input logic sel, input logic [31:0] data);
    idx_i    = idx;
    we_lo_i  = lo;
    we_hi_i  = hi;
    we_sel_i = sel;
    wdata_i  = data;
  endtask

  task automatic wr_off();
    we_lo_i  = 1'b0;
    we_hi_i  = 1'b0;
    we_sel_i = 1'b0;
  endtask

  task automatic push(input string tag, input logic [63:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed %0h expected <none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    events_i  = '0;
    inhibit_i = '0;
    idx_i     = '0;
    ovf_clr_i = '0;
    wdata_i   = '0;
    wr_off();
    tick();
    tick();

    push("rst_rdata", 64'h0);
    push("rst_sel", 64'h0);
    push("rst_ovf", 64'h0);
    push("rst_irq", 64'h0);
    rd(5'd0);
    check(a_rdata); check(64'(a_sel)); check(64'(a_ovf)); check(64'(a_irq));
    rst_ni = 1'b1;

    // Counter 0 counts event 0 for five cycles
    wr(5'd0, 1'b0, 1'b0, 1'b1, 32'd1);
    tick();
    wr_off();
    events_i = 16'h0001;
    push("c0_count5", 64'd5);
    push("c0_sel", 64'd1);
    push("c0_count5_w8", 64'd5);
    repeat (5) tick();
    events_i = '0;
    rd(5'd0);
    check(a_rdata); check(64'(a_sel)); check(b_rdata);
    for (int i = 1; i < 4; i++) begin
      push($sformatf("idle_c%0d", i), 64'h0);
      rd(5'(i));
      check(a_rdata);
    end

    // Counter 1: event 1, load 0xFF, one event wraps the 8-bit bank
    wr(5'd1, 1'b0, 1'b0, 1'b1, 32'd2);
    tick();
    wr(5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_00FF);
    tick();
    wr_off();
    push("c1_load", 64'hFF);
    check(a_rdata);
    events_i = 16'h0002;
    push("c1_wrap_w8", 64'h0);
    push("c1_ovf_w8", 64'h2);
    push("c1_irq_w8", 64'h1);
    push("c1_inc_w40", 64'h100);
    push("c1_ovf_w40", 64'h0);
    tick();
    events_i = '0;
    check(b_rdata); check(64'(b_ovf)); check(64'(b_irq));
    check(a_rdata); check(64'(a_ovf));
    ovf_clr_i = 4'b0010;
    push("c1_clr_ovf", 64'h0);
    push("c1_clr_irq", 64'h0);
    tick();
    ovf_clr_i = '0;
    check(64'(b_ovf)); check(64'(b_irq));

    // Counter 2: write beats a same-cycle increment
    wr(5'd2, 1'b0, 1'b0, 1'b1, 32'd3);
    tick();
    wr_off();
    events_i = 16'h0004;
    tick();
    tick();
    wr(5'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
    push("c2_wr_prio", 64'h100);
    push("c2_wr_trunc_w8", 64'h00);
    tick();
    wr_off();
    check(a_rdata); check(b_rdata);
    push("c2_after_wr", 64'h101);
    push("c2_after_wr_w8", 64'h01);
    tick();
    events_i = '0;
    check(a_rdata); check(b_rdata);
    wr(5'd2, 1'b0, 1'b1, 1'b0, 32'h0000_ABCD);
    push("c2_wr_hi", 64'hCD_0000_0101);
    push("c2_wr_hi_w8", 64'h01);
    tick();
    check(a_rdata); check(b_rdata);
    wr(5'd2, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    push("c2_wr_both", 64'h78_1234_5678);
    push("c2_wr_both_w8", 64'h78);
    tick();
    wr_off();
    check(a_rdata); check(b_rdata);

    // Counter 3: inhibit holds it, release lets it count
    wr(5'd3, 1'b0, 1'b0, 1'b1, 32'd4);
    tick();
    wr_off();
    inhibit_i = 4'b1000;
    events_i  = 16'h0008;
    push("c3_inhibit", 64'h0);
    repeat (10) tick();
    check(a_rdata);
    inhibit_i = '0;
    push("c3_release", 64'h3);
    repeat (3) tick();
    events_i = '0;
    check(a_rdata);

    // Out-of-range index: no write, reads zero
    wr(5'd30, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    push("idx30_rdata", 64'h0);
    push("idx30_sel", 64'h0);
    push("idx30_c0", 64'd5);
    push("idx30_c0_sel", 64'd1);
    push("idx30_c1", 64'h100);
    tick();
    wr_off();
    check(a_rdata); check(64'(a_sel));
    rd(5'd0);
    check(a_rdata); check(64'(a_sel));
    rd(5'd1);
    check(a_rdata);

    // Select change uses the old select on the same edge
    wr(5'd0, 1'b0, 1'b0, 1'b1, 32'd5);
    events_i = 16'h0001;
    push("c0_old_sel", 64'd6);
    tick();
    wr_off();
    check(a_rdata);
    push("c0_new_sel", 64'd6);
    push("c0_new_sel_val", 64'd5);
    tick();
    events_i = '0;
    check(a_rdata); check(64'(a_sel));

    // 8-bit counter 1 at all-ones: write beats increment, no overflow
    wr(5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_00FF);
    tick();
    events_i = 16'h0002;
    push("c1_wr_no_ovf_val", 64'hFF);
    push("c1_wr_no_ovf", 64'h0);
    tick();
    wr_off();
    check(b_rdata); check(64'(b_ovf));

    // Overflow set beats same-cycle clear
    ovf_clr_i = 4'b0010;
    push("c1_set_vs_clr_val", 64'h0);
    push("c1_set_vs_clr", 64'h2);
    push("c1_set_vs_clr_irq", 64'h1);
    tick();
    ovf_clr_i = '0;
    events_i  = '0;
    check(b_rdata); check(64'(b_ovf)); check(64'(b_irq));

    // Asynchronous reset mid-count
    events_i = 16'hFFFF;
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("arst_c%0d", i), 64'h0);
      rd(5'(i));
      check(a_rdata);
    end
    push("arst_sel", 64'h0);
    push("arst_ovf_w8", 64'h0);
    push("arst_irq_w8", 64'h0);
    check(64'(a_sel)); check(64'(b_ovf)); check(64'(b_irq));
    tick();
    rst_ni = 1'b1;
    wr(5'd0, 1'b0, 1'b0, 1'b1, 32'd1);
    tick();
    wr_off();
    push("post_rst_idle", 64'h0);
    check(a_rdata);
    push("post_rst_count", 64'h1);
    tick();
    events_i = '0;
    check(a_rdata);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
